// File: rtl/out_port_bcd_scanner_pkg.sv
// Shared types and constants for the out-port binary-to-BCD scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package out_port_bcd_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    // Digit shown on both nibbles when a port value cannot be displayed in two digits
    localparam logic [3:0] OVF_DIGIT = 4'hF;
    localparam int         NUM_PORTS = 3;

endpackage

// File: rtl/out_port_bcd_scanner_add3_shift.sv
// One double-dabble step: add 3 to any BCD nibble >= 5, then shift {bcd,bin} left by one.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module bcd_add3_shift #(
    parameter int BIN_W = 7
) (
    input  logic [7:0]       bcd_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic [7:0]       bcd_out,
    output logic [BIN_W-1:0] bin_out
);

    logic [7:0] bcd_adj;

    // Pre-correct each nibble so the following doubling carries correctly into the next digit
    always_comb begin
        bcd_adj = bcd_in;
        if (bcd_in[3:0] >= 4'd5) bcd_adj[3:0] = bcd_in[3:0] + 4'd3;
        if (bcd_in[7:4] >= 4'd5) bcd_adj[7:4] = bcd_in[7:4] + 4'd3;
    end

    assign bcd_out = {bcd_adj[6:0], bin_in[BIN_W-1]};
    assign bin_out = {bin_in[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/out_port_bcd_scanner.sv
// Round-robin binary-to-BCD converter for three CPU output ports feeding the seven-segment decoders.
// Latency: CONV_W+2 cycles per port (LOAD, CONV_W SHIFTs, STORE); 3*(CONV_W+2) cycles per frame.
// Backpressure: none; en=0 lets the port in flight finish, then parks in IDLE keeping the port index.
module out_port_bcd_scanner
    import out_port_bcd_scanner_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CONV_W  = 7,
    parameter int MAX_VAL = 99
) (
    input  logic            mem_clk,
    input  logic            reset,
    input  logic            en,
    input  logic [IN_W-1:0] out_port0,
    input  logic [IN_W-1:0] out_port1,
    input  logic [IN_W-1:0] out_port2,
    output logic [3:0]      hi0,
    output logic [3:0]      lo0,
    output logic [3:0]      hi1,
    output logic [3:0]      lo1,
    output logic [3:0]      hi2,
    output logic [3:0]      lo2,
    output logic [2:0]      ovf,
    output logic [2:0]      valid,
    output logic            frame_done
);

    localparam int              CNT_W    = $clog2(CONV_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_W - 1);
    localparam logic [IN_W-1:0]  MAX_VEC  = IN_W'(MAX_VAL);

    state_t            state, state_nxt;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  cnt;
    logic [IN_W-1:0]   snap;
    logic [CONV_W-1:0] bin;
    logic [7:0]        bcd;
    logic [7:0]        bcd_step;
    logic [CONV_W-1:0] bin_step;
    logic [IN_W-1:0]   port_sel;

    logic [3:0]        hi_q [NUM_PORTS];
    logic [3:0]        lo_q [NUM_PORTS];
    logic [2:0]        ovf_q;
    logic [2:0]        valid_q;
    logic              frame_done_q;

    bcd_add3_shift #(.BIN_W(CONV_W)) u_step (
        .bcd_in  (bcd),
        .bin_in  (bin),
        .bcd_out (bcd_step),
        .bin_out (bin_step)
    );

    // Select the port currently being scanned
    always_comb begin
        port_sel = out_port0;
        case (idx)
            2'd1:    port_sel = out_port1;
            2'd2:    port_sel = out_port2;
            default: port_sel = out_port0;
        endcase
    end

    // State register
    always_ff @(posedge mem_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: en is only looked at in IDLE and at the end of STORE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_nxt = ST_STORE;
            ST_STORE: state_nxt = en ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot, shift and per-port result registers; only port idx is written on STORE
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            idx          <= 2'd0;
            cnt          <= '0;
            snap         <= '0;
            bin          <= '0;
            bcd          <= '0;
            ovf_q        <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                hi_q[k] <= 4'd0;
                lo_q[k] <= 4'd0;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    snap <= port_sel;
                    bin  <= port_sel[CONV_W-1:0];
                    bcd  <= '0;
                    cnt  <= '0;
                end
                ST_SHIFT: begin
                    bcd <= bcd_step;
                    bin <= bin_step;
                    cnt <= cnt + 1'b1;
                end
                ST_STORE: begin
                    // Full-width compare so large or negative values never alias into 0..99
                    if (snap > MAX_VEC) begin
                        hi_q[idx]  <= OVF_DIGIT;
                        lo_q[idx]  <= OVF_DIGIT;
                        ovf_q[idx] <= 1'b1;
                    end else begin
                        hi_q[idx]  <= bcd[7:4];
                        lo_q[idx]  <= bcd[3:0];
                        ovf_q[idx] <= 1'b0;
                    end
                    valid_q[idx] <= 1'b1;
                    frame_done_q <= (idx == 2'd2);
                    idx          <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign hi0        = hi_q[0];
    assign lo0        = lo_q[0];
    assign hi1        = hi_q[1];
    assign lo1        = lo_q[1];
    assign hi2        = hi_q[2];
    assign lo2        = lo_q[2];
    assign ovf        = ovf_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_out_port_bcd_scanner.sv
// Directed bench for out_port_bcd_scanner with a frame scoreboard.
// Latency: frames expected every 27 cycles while en=1.
// Backpressure: en toggled to exercise the park-and-resume path.
module tb_out_port_bcd_scanner;

    logic        mem_clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [3:0]  hi0, lo0, hi1, lo1, hi2, lo2;
    logic [2:0]  ovf, valid;
    logic        frame_done;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [29:0] exp_q [$];
    logic [29:0] obs;
    logic [29:0] mon_exp;
    logic        fd_prev;

    always #5 mem_clk = ~mem_clk;

    out_port_bcd_scanner dut (
        .mem_clk    (mem_clk),
        .reset      (reset),
        .en         (en),
        .out_port0  (out_port0),
        .out_port1  (out_port1),
        .out_port2  (out_port2),
        .hi0        (hi0),
        .lo0        (lo0),
        .hi1        (hi1),
        .lo1        (lo1),
        .hi2        (hi2),
        .lo2        (lo2),
        .ovf        (ovf),
        .valid      (valid),
        .frame_done (frame_done)
    );

    assign obs = {hi0, lo0, hi1, lo1, hi2, lo2, ovf, valid};

    function automatic logic [29:0] mk(input logic [3:0] h0, input logic [3:0] l0,
                                       input logic [3:0] h1, input logic [3:0] l1,
                                       input logic [3:0] h2, input logic [3:0] l2,
                                       input logic [2:0] o,  input logic [2:0] v);
        return {h0, l0, h1, l1, h2, l2, o, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Advance to the next frame_done (visible in the LOAD cycle of port 0)
    task automatic wait_frame_done(input string name);
        int n = 0;
        do begin
            @(posedge mem_clk); #1;
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        if (frame_done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no frame_done within 40 cycles", name);
        end
    endtask

    // Count edges until valid[0] (use_fd=0) or frame_done (use_fd=1) rises
    task automatic measure(input string name, input int expect_cycles, input bit use_fd);
        int n   = 0;
        bit hit = 1'b0;
        while (!hit && n < 60) begin
            @(posedge mem_clk); #1;
            n++;
            hit = use_fd ? (frame_done === 1'b1) : (valid[0] === 1'b1);
        end
        check(name, n, expect_cycles);
    endtask

    // Monitor: every frame_done pops one expected frame and compares all outputs
    initial begin
        fd_prev = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (frame_done === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame: unexpected frame_done, outputs %h", obs);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (obs !== mon_exp || fd_prev) begin
                        miscompares++;
                        $display("FAIL frame: got %h (pulse_prev=%0b), expected %h", obs, fd_prev, mon_exp);
                    end
                end
            end
            fd_prev = frame_done;
        end
    end

    initial begin
        int bad;
        reset     = 1'b1;
        en        = 1'b1;
        out_port0 = 32'd37;
        out_port1 = 32'd5;
        out_port2 = 32'd99;
        repeat (3) @(posedge mem_clk);
        #1;
        check("reset_state", {obs, frame_done}, 31'd0);

        // Frame 1: basic conversion straight out of reset
        exp_q.push_back(mk(4'd3, 4'd7, 4'd0, 4'd5, 4'd9, 4'd9, 3'b000, 3'b111));
        reset = 1'b0;
        measure("t1_port0_latency", 10, 1'b0);
        wait_frame_done("t1_frame");

        // Overflow on ports 1 and 2
        out_port1 = 32'd100;
        out_port2 = 32'hFFFF_FFFF;
        exp_q.push_back(mk(4'd3, 4'd7, 4'hF, 4'hF, 4'hF, 4'hF, 3'b110, 3'b111));
        wait_frame_done("t2_ovf_frame");
        out_port1 = 32'd42;
        exp_q.push_back(mk(4'd3, 4'd7, 4'd4, 4'd2, 4'hF, 4'hF, 3'b100, 3'b111));
        wait_frame_done("t2_clear_frame");

        // Port change right after LOAD must not affect the conversion in flight
        out_port0 = 32'd12;
        exp_q.push_back(mk(4'd1, 4'd2, 4'd4, 4'd2, 4'hF, 4'hF, 3'b100, 3'b111));
        @(posedge mem_clk); #1;
        out_port0 = 32'd88;
        wait_frame_done("t3_snap_frame");
        exp_q.push_back(mk(4'd8, 4'd8, 4'd4, 4'd2, 4'hF, 4'hF, 3'b100, 3'b111));
        wait_frame_done("t3_next_frame");

        // en=0 during port1 SHIFT: port0 and port1 store, then the scanner parks
        out_port0 = 32'd21;
        out_port1 = 32'd64;
        out_port2 = 32'd7;
        repeat (12) @(posedge mem_clk);
        #1;
        en = 1'b0;
        repeat (15) @(posedge mem_clk);
        #1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge mem_clk); #1;
            if (obs !== mk(4'd2, 4'd1, 4'd6, 4'd4, 4'hF, 4'hF, 3'b100, 3'b111) || frame_done !== 1'b0)
                bad++;
        end
        check("t4_idle_hold_bad_cycles", bad, 0);
        en = 1'b1;
        exp_q.push_back(mk(4'd2, 4'd1, 4'd6, 4'd4, 4'd0, 4'd7, 3'b000, 3'b111));
        measure("t4_resume_port2_first", 10, 1'b1);

        // Reset in the middle of port2's SHIFT
        out_port0 = 32'd50;
        out_port1 = 32'd60;
        out_port2 = 32'd70;
        repeat (21) @(posedge mem_clk);
        #1;
        reset = 1'b1;
        @(posedge mem_clk); #1;
        check("t5_reset_mid_shift", {obs, frame_done}, 31'd0);

        // Sweep port0 over 0..99, one value per frame
        out_port0 = 32'd0;
        out_port1 = 32'd100;
        out_port2 = 32'd9;
        exp_q.push_back(mk(4'd0, 4'd0, 4'hF, 4'hF, 4'd0, 4'd9, 3'b010, 3'b111));
        reset = 1'b0;
        measure("t5_restart_from_port0", 10, 1'b0);
        for (int v = 1; v < 100; v++) begin
            wait_frame_done("t6_sweep_frame");
            out_port0 = 32'(v);
            exp_q.push_back(mk(4'(v / 10), 4'(v % 10), 4'hF, 4'hF, 4'd0, 4'd9, 3'b010, 3'b111));
        end
        wait_frame_done("t6_last_frame");
        @(negedge mem_clk);
        @(posedge mem_clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
